// File: rtl/dds_cmd_pkg.sv
// Shared constants, command table and FSM state type for the DDS command parser.
package dds_cmd_pkg;

   localparam logic [7:0] HDR_BYTE  = 8'h55;
   localparam logic [7:0] CMD_FWORD = 8'h01;
   localparam logic [7:0] CMD_PWORD = 8'h02;
   localparam logic [7:0] CMD_EN    = 8'h03;

   localparam logic [2:0] LEN_FWORD = 3'd4;
   localparam logic [2:0] LEN_PWORD = 3'd2;
   localparam logic [2:0] LEN_EN    = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_PAYLOAD,
      ST_CHK
   } state_t;

   function automatic logic cmd_valid(input logic [7:0] cmd);
      return (cmd == CMD_FWORD) || (cmd == CMD_PWORD) || (cmd == CMD_EN);
   endfunction

   function automatic logic [2:0] payload_len(input logic [7:0] cmd);
      case (cmd)
         CMD_FWORD: return LEN_FWORD;
         CMD_PWORD: return LEN_PWORD;
         CMD_EN:    return LEN_EN;
         default:   return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dds_cmd_parser.sv
// Framed byte-command parser driving the DDS fword/pword/en registers.
// Frame: 0x55, cmd, payload (MSB first), checksum = (cmd + payload) mod 256.
module dds_cmd_parser
   import dds_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned CNT_W          = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic [31:0] fword,
   output logic [11:0] pword,
   output logic        en,
   output logic        cmd_ok,
   output logic        cmd_err
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_nx;
   logic [7:0]        cmd_q;
   logic [2:0]        cnt_q;
   logic [7:0]        sum_q;
   logic [31:0]       stage_q;
   logic [CNT_W-1:0]  tmo_q;

   logic timeout;
   logic ld_cmd;
   logic shift_en;
   logic accept;
   logic err_nx;

   // A byte arriving on the expiry cycle takes priority over the abort.
   assign timeout = (state_q != ST_IDLE) && !rx_done && (tmo_q == TMO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      ld_cmd   = 1'b0;
      shift_en = 1'b0;
      accept   = 1'b0;
      err_nx   = 1'b0;
      if (timeout) begin
         state_nx = ST_IDLE;
         err_nx   = 1'b1;
      end else if (rx_done) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_data == HDR_BYTE) state_nx = ST_CMD;
            end
            ST_CMD: begin
               if (cmd_valid(rx_data)) begin
                  ld_cmd   = 1'b1;
                  state_nx = ST_PAYLOAD;
               end else begin
                  err_nx   = 1'b1;
                  state_nx = ST_IDLE;
               end
            end
            ST_PAYLOAD: begin
               shift_en = 1'b1;
               if (cnt_q == 3'd1) state_nx = ST_CHK;
            end
            ST_CHK: begin
               state_nx = ST_IDLE;
               if (rx_data == sum_q) accept = 1'b1;
               else                  err_nx = 1'b1;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         stage_q <= '0;
         tmo_q   <= '0;
         fword   <= '0;
         pword   <= '0;
         en      <= 1'b0;
         cmd_ok  <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         cmd_ok  <= accept;
         cmd_err <= err_nx;

         if ((state_q == ST_IDLE) || rx_done) tmo_q <= '0;
         else                                 tmo_q <= tmo_q + 1'b1;

         if (timeout) begin
            cnt_q   <= '0;
            sum_q   <= '0;
            stage_q <= '0;
         end else if (ld_cmd) begin
            cmd_q   <= rx_data;
            cnt_q   <= payload_len(rx_data);
            sum_q   <= rx_data;
            stage_q <= '0;
         end else if (shift_en) begin
            stage_q <= {stage_q[23:0], rx_data};
            sum_q   <= sum_q + rx_data;
            cnt_q   <= cnt_q - 3'd1;
         end

         // Staging is right-aligned, so pword/en take the low bits directly.
         if (accept) begin
            case (cmd_q)
               CMD_FWORD: fword <= stage_q;
               CMD_PWORD: pword <= stage_q[11:0];
               CMD_EN:    en    <= stage_q[0];
               default:   ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Self-checking bench for dds_cmd_parser: directed frames plus randomized frame traffic.
module tb_dds_cmd_parser;

   localparam int T = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_done = 1'b0;
   logic [31:0] fword;
   logic [11:0] pword;
   logic        en;
   logic        cmd_ok;
   logic        cmd_err;

   dds_cmd_parser #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_data (rx_data),
      .rx_done (rx_done),
      .fword   (fword),
      .pword   (pword),
      .en      (en),
      .cmd_ok  (cmd_ok),
      .cmd_err (cmd_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int ok_seen = 0;
   int err_seen = 0;

   // Reference model: list of bytes collected since the header.
   logic        m_in = 1'b0;
   logic [7:0]  mq[$];
   int          m_gap = 0;
   logic [31:0] m_fword = '0;
   logic [11:0] m_pword = '0;
   logic        m_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int plen(input logic [7:0] c);
      case (c)
         8'h01:   return 4;
         8'h02:   return 2;
         8'h03:   return 1;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_in = 1'b0;
      mq.delete();
      m_gap = 0;
      m_fword = '0;
      m_pword = '0;
      m_en = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b, output logic ok, output logic err);
      int unsigned s;
      longint unsigned v;
      ok = 1'b0;
      err = 1'b0;
      if (!m_in) begin
         if (b == 8'h55) begin
            m_in = 1'b1;
            mq.delete();
         end
      end else begin
         mq.push_back(b);
         if (mq.size() == 1 && plen(b) == 0) begin
            err = 1'b1;
            m_in = 1'b0;
         end else if (mq.size() == plen(mq[0]) + 2) begin
            s = 0;
            for (int i = 0; i < mq.size() - 1; i++) s += mq[i];
            if (8'(s) == b) begin
               ok = 1'b1;
               v = 0;
               for (int i = 1; i < mq.size() - 1; i++) v = v * 256 + mq[i];
               case (mq[0])
                  8'h01:   m_fword = 32'(v);
                  8'h02:   m_pword = 12'(v % 4096);
                  default: m_en = v[0];
               endcase
            end else begin
               err = 1'b1;
            end
            m_in = 1'b0;
         end
      end
   endtask

   task automatic tick(input logic done, input logic [7:0] d, input string tag);
      logic eo, ee;
      @(negedge clk);
      rx_done = done;
      rx_data = d;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      eo = 1'b0;
      ee = 1'b0;
      if (done) begin
         model_byte(d, eo, ee);
         m_gap = 0;
      end else if (m_in) begin
         m_gap++;
         if (m_gap == T) begin
            ee = 1'b1;
            m_in = 1'b0;
         end
      end
      ok_seen += int'(cmd_ok);
      err_seen += int'(cmd_err);
      check(tag, 64'({cmd_ok, cmd_err, en, pword, fword}), 64'({eo, ee, m_en, m_pword, m_fword}));
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
      repeat (gap) tick(1'b0, 8'h00, tag);
      tick(1'b1, b, tag);
   endtask

   function automatic int gap_pick();
      if ($urandom_range(0, 19) < 17) return $urandom_range(0, 3);
      return T - 2 + $urandom_range(0, 2);
   endfunction

   logic [7:0] fr[$];
   int o0, e0, kind, keep;
   logic [7:0] c, p, s8;

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({cmd_ok, cmd_err, en, pword, fword}), 64'(0));
      @(negedge clk);
      rst = 1'b1;

      // fword frame
      o0 = ok_seen;
      fr = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h11};
      foreach (fr[i]) send_byte(fr[i], 0, "fword_frame");
      send_byte(8'h00, 2, "fword_tail");
      check("fword_value", 64'(fword), 64'h0000_1000);
      check("fword_ok_pulses", 64'(ok_seen - o0), 64'd1);
      check("fword_others_hold", 64'({pword, en}), 64'(0));

      // pword (upper nibble ignored) and en
      fr = '{8'h55, 8'h02, 8'hF8, 8'h00, 8'hFA, 8'h55, 8'h03, 8'h01, 8'h04};
      foreach (fr[i]) send_byte(fr[i], 1, "pword_en_frames");
      send_byte(8'h00, 1, "pword_en_tail");
      check("pword_value", 64'(pword), 64'h800);
      check("en_value", 64'(en), 64'd1);

      // bad checksum, then unknown command
      e0 = err_seen;
      fr = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h12, 8'h55, 8'h07};
      foreach (fr[i]) send_byte(fr[i], 0, "bad_frames");
      send_byte(8'h00, 1, "bad_tail");
      check("bad_err_pulses", 64'(err_seen - e0), 64'd2);
      check("bad_fword_hold", 64'(fword), 64'h0000_1000);

      // stall timeout, then a valid frame
      e0 = err_seen;
      o0 = ok_seen;
      fr = '{8'h55, 8'h01, 8'h00};
      foreach (fr[i]) send_byte(fr[i], 0, "stall_frame");
      repeat (T + 2) tick(1'b0, 8'h00, "stall_wait");
      fr = '{8'h55, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
      foreach (fr[i]) send_byte(fr[i], 0, "after_stall");
      send_byte(8'h00, 1, "after_stall_tail");
      check("stall_err_pulses", 64'(err_seen - e0), 64'd1);
      check("after_stall_fword", 64'(fword), 64'h1234_5678);
      check("after_stall_ok", 64'(ok_seen - o0), 64'd1);

      // bytes arriving exactly on the expiry cycle
      e0 = err_seen;
      fr = '{8'h55, 8'h02, 8'h0A, 8'hBC, 8'hC8};
      foreach (fr[i]) send_byte(fr[i], (i == 0) ? 0 : T - 1, "expiry_edge");
      send_byte(8'h00, 1, "expiry_tail");
      check("expiry_no_err", 64'(err_seen - e0), 64'd0);
      check("expiry_pword", 64'(pword), 64'hABC);

      // stray bytes, then payload full of 0x55
      e0 = err_seen;
      o0 = ok_seen;
      fr = '{8'h00, 8'hAA, 8'h13};
      foreach (fr[i]) send_byte(fr[i], 0, "stray");
      check("stray_no_pulses", 64'((ok_seen - o0) + (err_seen - e0)), 64'd0);
      fr = '{8'h55, 8'h01, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
      foreach (fr[i]) send_byte(fr[i], 0, "payload_55");
      send_byte(8'h00, 1, "payload_55_tail");
      check("payload_55_fword", 64'(fword), 64'h5555_5555);

      // reset mid-payload
      fr = '{8'h55, 8'h03, 8'h01, 8'h04, 8'h55, 8'h02, 8'h01};
      foreach (fr[i]) send_byte(fr[i], 0, "pre_reset");
      check("pre_reset_en", 64'(en), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_async", 64'({cmd_ok, cmd_err, en, pword, fword}), 64'(0));
      model_reset();
      repeat (3) tick(1'b0, 8'h00, "in_reset");
      @(negedge clk);
      rst = 1'b1;
      fr = '{8'h55, 8'h03, 8'h01, 8'h04};
      foreach (fr[i]) send_byte(fr[i], 0, "post_reset");
      send_byte(8'h00, 1, "post_reset_tail");
      check("post_reset_en", 64'(en), 64'd1);

      // randomized frame traffic
      for (int f = 0; f < 250; f++) begin
         kind = $urandom_range(0, 9);
         fr.delete();
         if (kind == 0) begin
            p = 8'($urandom);
            if (p == 8'h55) p = 8'h00;
            fr.push_back(p);
         end else begin
            c = (kind == 1) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(1, 3));
            fr.push_back(8'h55);
            fr.push_back(c);
            if (kind != 1) begin
               s8 = c;
               for (int i = 0; i < plen(c); i++) begin
                  p = ($urandom_range(0, 5) == 0) ? 8'h55 : 8'($urandom);
                  fr.push_back(p);
                  s8 = s8 + p;
               end
               if (kind == 2) s8 = s8 ^ 8'($urandom_range(1, 255));
               fr.push_back(s8);
               if (kind == 3) begin
                  keep = $urandom_range(1, fr.size() - 2);
                  while (fr.size() > keep) void'(fr.pop_back());
               end
            end
         end
         foreach (fr[i]) send_byte(fr[i], gap_pick(), "random");
         if (kind == 3) repeat (T + 2) tick(1'b0, 8'h00, "random_stall");
      end
      repeat (T + 2) tick(1'b0, 8'h00, "final_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
